// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad and turns each debounced key press
//   into a single-cycle {row, col} code on key_coord.
//
//   Output protocol: key_coord is a push-only event stream with no ready.
//   A nonzero value is valid for exactly the one cycle in which it appears,
//   and the consumer must take it in that cycle. 8'h00 means "no event".
//
// Parameters
//   SCAN_DIV      clk cycles per column dwell (>= 2); rows sampled on the last
//   DEBOUNCE_CNT  identical samples needed to accept a press or a release (>= 1)
//
// Ports
//   clk        system clock, posedge
//   rst        synchronous active-high reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    active-low one-hot column strobe
//   key_coord  {row, col} active-low code for one cycle per press, else 8'h00
//   key_held   high while a debounced key is held
//   state_dbg  current FSM state (0 SCAN, 1 DEBOUNCE, 2 HOLD)

module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV     = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_CNT = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [7:0] key_coord,
    output logic       key_held,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [3:0]  row_m, row_s;
    logic [15:0] dwell_q, dwell_n;
    logic [3:0]  col_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [7:0]  code_q, code_n;
    logic [7:0]  coord_n;
    logic        held_n;

    logic        sample;
    logic        single_low;
    logic [3:0]  row_low;
    logic [3:0]  col_rot;

    // Two-flop synchronizer; everything downstream looks at row_s only.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_m <= 4'b1111;
            row_s <= 4'b1111;
        end else begin
            row_m <= row_in;
            row_s <= row_m;
        end
    end

    assign sample  = (dwell_q == SCAN_DIV - 16'd1);
    assign row_low = ~row_s;
    // Exactly one row low; two or more is a ghost/multi-key pattern.
    assign single_low = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
    assign col_rot = {col_out[2:0], col_out[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCAN;
            dwell_q   <= 16'd0;
            col_out   <= 4'b1110;
            cnt_q     <= 4'd0;
            code_q    <= 8'h00;
            key_coord <= 8'h00;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_n;
            dwell_q   <= dwell_n;
            col_out   <= col_n;
            cnt_q     <= cnt_n;
            code_q    <= code_n;
            key_coord <= coord_n;
            key_held  <= held_n;
        end
    end

    always_comb begin
        state_n = state_q;
        dwell_n = sample ? 16'd0 : dwell_q + 16'd1;
        col_n   = col_out;
        cnt_n   = cnt_q;
        code_n  = code_q;
        coord_n = 8'h00;
        held_n  = key_held;

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (single_low) begin
                        // The detecting sample already counts as the first match.
                        code_n  = {row_s, col_out};
                        cnt_n   = 4'd1;
                        state_n = DEBOUNCE;
                    end else begin
                        col_n = col_rot;
                    end
                end
            end

            DEBOUNCE: begin
                // Counter reaching the threshold is acted on one cycle later;
                // that cycle is never a sample point since SCAN_DIV >= 2.
                if (cnt_q == DEBOUNCE_CNT) begin
                    coord_n = code_q;
                    held_n  = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = HOLD;
                end else if (sample) begin
                    if (row_s == code_q[7:4]) begin
                        cnt_n = cnt_q + 4'd1;
                    end else begin
                        cnt_n   = 4'd0;
                        col_n   = col_rot;
                        state_n = SCAN;
                    end
                end
            end

            HOLD: begin
                // Release debounce reuses cnt_q; any non-idle sample restarts it,
                // so a second key pressed meanwhile simply delays the release.
                if (sample) begin
                    if (row_s == 4'b1111) begin
                        if (cnt_q + 4'd1 == DEBOUNCE_CNT) begin
                            held_n  = 1'b0;
                            col_n   = 4'b1110;
                            dwell_n = 16'd0;
                            cnt_n   = 4'd0;
                            state_n = SCAN;
                        end else begin
                            cnt_n = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_n = 4'd0;
                    end
                end
            end

            default: begin
                state_n = SCAN;
                col_n   = 4'b1110;
                cnt_n   = 4'd0;
                held_n  = 1'b0;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad and produces the `key_coord` event stream consumed by the input unit.
- Rotates an active-low column strobe and samples the active-low row lines through a synchronizer.
- Debounces both press and release.
- Emits exactly one single-cycle `{row_val, col_val}` code per physical key press, and 8'h00 at all other times.

Parameters:
- SCAN_DIV, 16'd50000, clk cycles per column dwell; row sample taken on the last cycle of each dwell; legal range ≥ 2.
- DEBOUNCE_CNT, 4'd4, consecutive identical samples required to accept a press or a release; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all logic is on the posedge.
- rst  input  1  synchronous, active-high reset.
- row_in  input  4  keypad rows, active-low, asynchronous to clk; bit i low = row i pressed.
- col_out  output  4  column strobe, active-low one-hot; bit j low = column j driven.
- key_coord  output  8  {row_val, col_val} active-low code, held 1 cycle per press; 8'h00 otherwise.
- key_held  output  1  high while a debounced key is held (HOLD state).

Behaviour:
- Reset: on a clk edge with rst=1:
  - col_out=4'b1110, key_coord=8'h00, key_held=0.
  - state=SCAN, dwell counter=0, debounce counter=0, captured code=0.
  - synchronizer flops=4'b1111.
  - rst overrides everything; reset mid-DEBOUNCE or mid-HOLD discards the capture and emits no event.
- Synchronizer: row_in passes through 2 flops to give row_s; all decisions use row_s only.
- Dwell counter: counts 0..SCAN_DIV-1 and wraps; "sample point" = the cycle where the counter equals SCAN_DIV-1.
- SCAN state:
  - At each sample point, if row_s has exactly one bit low: capture {row_s, col_out}, set debounce counter=1, go DEBOUNCE, keep col_out.
  - Otherwise (all high, or ≥2 bits low = ghost/multi-key): rotate col_out 1110→1101→1011→0111→1110 on the cycle after the sample point.
- DEBOUNCE state (col_out frozen):
  - At each sample point, if row_s equals the captured row nibble, increment the counter.
  - When the counter reaches DEBOUNCE_CNT (immediately if DEBOUNCE_CNT=1): on the next clk key_coord = captured code for exactly 1 cycle; go HOLD; key_held=1.
  - Any mismatching sample: clear the counter, return to SCAN, advance to the next column.
- HOLD state (col_out frozen, key_coord=0):
  - At each sample point, row_s=4'b1111 increments the release counter; anything else clears it.
  - At DEBOUNCE_CNT: key_held=0, col_out=4'b1110, dwell counter=0, go SCAN.
  - No repeat events while held; a second key pressed while held is ignored.
- key_coord: registered output, never holds a value for more than 1 cycle; it is 8'h00 whenever no valid event exists.
  - Codes match the keypad map, e.g. '1'=8'hEE, '0'=8'h7D, '*'=8'h7E, '#'=8'h7B, 'A'=8'hE7, 'B'=8'hD7.
- Latency (press stable before the sample point): event arrives ≤ (4 + DEBOUNCE_CNT)·SCAN_DIV + 3 cycles after the press.
- Minimum inter-event spacing: 2·DEBOUNCE_CNT·SCAN_DIV cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset 2 cycles, then row_in=1111 for 100 cycles → key_coord stays 00; col_out cycles 1110,1101,1011,0111 with each value held 4 cycles; key_held=0.
- Row0 held low only while col_out=1110 ('1') → exactly one key_coord=8'hEE pulse; key_held=1 until 3 released samples; repeat for row3/col1 → single 8'h7D.
- Hold 'A' (row0 with col3) for 300 cycles → exactly one 8'hE7 pulse; release, then press again → a second 8'hE7 pulse.
- Bounce: row1 low for 1 sample, high for the next, on col0 → no pulse; scanning resumes at col 1101.
- Ghost: row0 and row1 low simultaneously on col0 → no pulse, col_out keeps rotating.
- Assert rst during DEBOUNCE, after 2 matching samples → no pulse ever appears; col_out=1110 on the next cycle; a fresh press after reset is detected normally.
